// File: rtl/mem_port.sv
// Load/store port: turns one-cycle load/store commands into a req/ack
// transaction on a byte-wide memory bus, with a bounded wait before abort.
module mem_port #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] mem_out,
    output logic              mem_done,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_sat;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                we_reg, we_next;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   mem_out_reg, mem_out_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            mem_out_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            we_reg      <= we_next;
            err_reg     <= err_next;
            mem_out_reg <= mem_out_next;
        end
    end

    // Saturating count of unacknowledged request cycles
    assign cnt_sat = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        we_next      = we_reg;
        err_next     = err_reg;
        mem_out_next = mem_out_reg;
        case (state_reg)
            S_IDLE: begin
                if (ld_en && st_en) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (ld_en || st_en) begin
                    addr_next  = addr;
                    wdata_next = wdata;
                    we_next    = st_en;
                    cnt_next   = '0;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the last allowed cycle still completes normally
                if (bus_ack) begin
                    if (!we_reg) begin
                        mem_out_next = bus_rdata;
                    end
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_sat;
                    if (cnt_sat == CNT_LAST) begin
                        if (!we_reg) begin
                            mem_out_next = '1;
                        end
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                err_next   = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_reg != S_IDLE);
        bus_req   = (state_reg == S_REQ);
        mem_done  = (state_reg == S_DONE);
        mem_err   = (state_reg == S_DONE) && err_reg;
        bus_we    = we_reg;
        bus_addr  = addr_reg;
        bus_wdata = wdata_reg;
        mem_out   = mem_out_reg;
    end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: a transaction-level model sets the expected
// outputs for each cycle and a single negedge process compares them.
module tb_mem_port;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_en = 1'b0;
    logic       st_en = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       bus_ack = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic       busy, mem_done, mem_err, bus_req, bus_we;
    logic [7:0] mem_out, bus_addr, bus_wdata;

    mem_port #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_en    (ld_en),
        .st_en    (st_en),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .mem_out  (mem_out),
        .mem_done (mem_done),
        .mem_err  (mem_err),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle (reset values to start)
    logic       exp_busy = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
    logic       exp_done = 1'b0, exp_err = 1'b0;
    logic [7:0] exp_addr = 8'h00, exp_wdata = 8'h00, exp_mem_out = 8'h00;
    bit         exp_bus_chk = 1'b1, exp_wd_chk = 1'b1;
    logic [7:0] model_mem_out = 8'h00;

    // Hand-computed literal pins, checked by the compare process
    bit         pin_mem_on = 1'b0;
    logic [7:0] pin_mem_val = 8'h00;
    bit         pin_run_on = 1'b0;
    int         pin_run_val = 0;

    int checks = 0;
    int failures = 0;
    int run_len = 0;
    int last_run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                run_len++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len = 0;
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("bus_req", 32'(bus_req), 32'(exp_req));
            chk("mem_done", 32'(mem_done), 32'(exp_done));
            chk("mem_err", 32'(mem_err), 32'(exp_err));
            chk("mem_out", 32'(mem_out), 32'(exp_mem_out));
            if (exp_bus_chk) begin
                chk("bus_we", 32'(bus_we), 32'(exp_we));
                chk("bus_addr", 32'(bus_addr), 32'(exp_addr));
            end
            if (exp_wd_chk) begin
                chk("bus_wdata", 32'(bus_wdata), 32'(exp_wdata));
            end
            if (pin_mem_on) begin
                chk("pin_mem_out", 32'(mem_out), 32'(pin_mem_val));
            end
            if (pin_run_on) begin
                chk("pin_req_cycles", 32'(last_run), 32'(pin_run_val));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_busy    = 1'b0;
        exp_req     = 1'b0;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_bus_chk = 1'b0;
        exp_wd_chk  = 1'b0;
        exp_mem_out = model_mem_out;
    endtask

    // ack_at: REQ cycle (1-based) carrying bus_ack, 0 = never.
    // rst_at: REQ cycle in which reset is asserted, 0 = never.
    // pin_mem/pin_run: literal expectations for the DONE cycle, -1 = none.
    task automatic do_cmd(input bit ld, input bit st, input logic [7:0] a,
                          input logic [7:0] d, input int ack_at, input logic [7:0] rd,
                          input bit poke, input int rst_at, input int pin_mem,
                          input int pin_run);
        bit acked;
        $display("txn ld=%0b st=%0b addr=%02h wdata=%02h ack_at=%0d rdata=%02h poke=%0b rst_at=%0d",
                 ld, st, a, d, ack_at, rd, poke, rst_at);
        ld_en = ld;
        st_en = st;
        addr  = a;
        wdata = d;
        tick();
        ld_en = 1'b0;
        st_en = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;
        if (ld && st) begin
            exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b1; exp_err = 1'b1;
            exp_bus_chk = 1'b0; exp_wd_chk = 1'b0;
            tick();
            set_idle();
            return;
        end
        acked = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            exp_busy = 1'b1; exp_req = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
            exp_we = st; exp_addr = a; exp_wdata = d;
            exp_bus_chk = 1'b1; exp_wd_chk = st;
            if (rst_at == k) begin
                model_mem_out = 8'h00;
                exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
                exp_addr = 8'h00; exp_wdata = 8'h00; exp_mem_out = 8'h00;
                exp_wd_chk = 1'b1;
                pin_mem_on = 1'b1; pin_mem_val = 8'h00;
                rst_n = 1'b0;
                tick();
                pin_mem_on = 1'b0;
                tick();
                rst_n = 1'b1;
                set_idle();
                tick();
                return;
            end
            if (poke && k == 2) begin
                ld_en = 1'b1;
                addr  = 8'hEE;
            end
            if (k == ack_at) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            tick();
            ld_en = 1'b0;
            addr = 8'h00;
            bus_ack = 1'b0;
            bus_rdata = 8'h00;
            if (k == ack_at) begin
                acked = 1'b1;
                break;
            end
        end
        if (ld) begin
            model_mem_out = acked ? rd : 8'hFF;
        end
        exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b1; exp_err = !acked;
        exp_mem_out = model_mem_out;
        exp_bus_chk = 1'b0; exp_wd_chk = 1'b0;
        if (pin_mem >= 0) begin
            pin_mem_on = 1'b1;
            pin_mem_val = 8'(pin_mem);
        end
        if (pin_run >= 0) begin
            pin_run_on = 1'b1;
            pin_run_val = pin_run;
        end
        tick();
        pin_mem_on = 1'b0;
        pin_run_on = 1'b0;
        set_idle();
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        set_idle();
        tick();
        // zero-wait load
        do_cmd(1'b1, 1'b0, 8'h3C, 8'h00, 1, 8'hA5, 1'b0, 0, 'hA5, 1);
        // store with 3 wait states, mem_out untouched
        do_cmd(1'b0, 1'b1, 8'h10, 8'h5A, 4, 8'h99, 1'b0, 0, 'hA5, 4);
        // load timeout
        do_cmd(1'b1, 1'b0, 8'h77, 8'h00, 0, 8'h00, 1'b0, 0, 'hFF, 15);
        // ack on the final allowed cycle wins over timeout
        do_cmd(1'b1, 1'b0, 8'h80, 8'h00, 15, 8'h01, 1'b0, 0, 'h01, 15);
        // both commands together
        do_cmd(1'b1, 1'b1, 8'h22, 8'h33, 0, 8'h00, 1'b0, 0, -1, -1);
        // back-to-back store then stray ack in idle
        do_cmd(1'b0, 1'b1, 8'hF0, 8'hC7, 2, 8'h00, 1'b0, 0, 'h01, 2);
        $display("txn stray bus_ack in IDLE");
        bus_ack = 1'b1;
        bus_rdata = 8'h5E;
        tick();
        bus_ack = 1'b0;
        bus_rdata = 8'h00;
        tick();
        // dropped command while busy, then reset mid-REQ
        do_cmd(1'b1, 1'b0, 8'h44, 8'h00, 0, 8'h00, 1'b1, 4, -1, -1);
        do_cmd(1'b1, 1'b0, 8'h55, 8'h00, 2, 8'hC3, 1'b0, 0, 'hC3, 2);
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
